// File: rtl/tmds_align_ctrl.sv
// tmds_align_ctrl: finds the TMDS word boundary by hunting for runs of control
// tokens, slipping the recovery block's word boundary one bit at a time.
// Optional macro TMDS_ALIGN_INVERT_EN: toggle the channel inversion request
// each time the slip phase wraps 9->0, so the search also covers swapped polarity.
module tmds_align_ctrl #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOSS_WINDOW   = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       word_valid,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic [3:0] phase,
  output logic       locked,
  output logic       lock_lost,
  output logic       invert
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_WINDOW + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [LOSS_W-1:0]   loss_cnt, loss_nxt;
  logic                bitslip_nxt, locked_nxt, lock_lost_nxt, invert_nxt;
  logic [3:0]          phase_nxt;
  logic                is_token;

  // Recognise the four DVI control-period tokens
  always_comb begin
    is_token = 1'b0;
    case (tmds_word)
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011: is_token = 1'b1;
      default:        is_token = 1'b0;
    endcase
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
      bitslip    <= 1'b0;
      phase      <= 4'd0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      invert     <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      win_cnt    <= win_nxt;
      settle_cnt <= settle_nxt;
      loss_cnt   <= loss_nxt;
      bitslip    <= bitslip_nxt;
      phase      <= phase_nxt;
      locked     <= locked_nxt;
      lock_lost  <= lock_lost_nxt;
      invert     <= invert_nxt;
    end
  end

  // Next-state, counter and output decode; lock beats window expiry
  always_comb begin
    state_nxt     = state;
    run_nxt       = run_cnt;
    win_nxt       = win_cnt;
    settle_nxt    = settle_cnt;
    loss_nxt      = loss_cnt;
    bitslip_nxt   = 1'b0;
    locked_nxt    = 1'b0;
    lock_lost_nxt = 1'b0;
    phase_nxt     = phase;
    invert_nxt    = invert;

    case (state)
      SEARCH: begin
        if (word_valid) begin
          win_nxt = win_cnt + WIN_W'(1);
          run_nxt = is_token ? run_cnt + RUN_W'(1) : '0;
          if (is_token && (run_cnt == RUN_W'(CTRL_RUN - 1))) begin
            state_nxt  = LOCKED;
            locked_nxt = 1'b1;
            loss_nxt   = '0;
          end else if (win_cnt == WIN_W'(SEARCH_WINDOW - 1)) begin
            state_nxt = SLIP;
          end
        end
      end

      SLIP: begin
        bitslip_nxt = 1'b1;
        state_nxt   = SETTLE;
        settle_nxt  = '0;
        run_nxt     = '0;
        win_nxt     = '0;
        if (phase == 4'd9) begin
          phase_nxt = 4'd0;
`ifdef TMDS_ALIGN_INVERT_EN
          invert_nxt = ~invert;
`else
          invert_nxt = 1'b0;
`endif
        end else begin
          phase_nxt = phase + 4'd1;
        end
      end

      SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end

      LOCKED: begin
        locked_nxt = 1'b1;
        if (word_valid) begin
          if (is_token) begin
            loss_nxt = '0;
          end else if (loss_cnt == LOSS_W'(LOSS_WINDOW - 1)) begin
            loss_nxt      = '0;
            locked_nxt    = 1'b0;
            lock_lost_nxt = 1'b1;
            state_nxt     = SLIP;
          end else begin
            loss_nxt = loss_cnt + LOSS_W'(1);
          end
        end
      end

      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// tb_tmds_align_ctrl: directed and randomized bench for tmds_align_ctrl with a
// timeline-based reference model (slip/settle tracked as absolute cycle numbers).
module tb_tmds_align_ctrl;

  localparam int unsigned CTRL_RUN      = 8;
  localparam int unsigned SEARCH_WINDOW = 16;
  localparam int unsigned SETTLE_CYCLES = 16;
  localparam int unsigned LOSS_WINDOW   = 2048;
`ifdef TMDS_ALIGN_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       word_valid = 1'b0;
  logic [9:0] tmds_word = 10'd0;
  logic       bitslip;
  logic [3:0] phase;
  logic       locked;
  logic       lock_lost;
  logic       invert;

  always #5 clk = ~clk;

  tmds_align_ctrl #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_valid (word_valid),
    .tmds_word  (tmds_word),
    .bitslip    (bitslip),
    .phase      (phase),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .invert     (invert)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: cycle numbers of scheduled events, plain counts
  int cyc;
  int m_run, m_win, m_loss;
  bit m_locked;
  int m_settle_end, m_slip_at, m_lost_at;
  int m_phase;
  bit m_invert;
  // Emulated recovery block and observed slip history
  int rx_off;
  int slip_count;
  int last_slip_cyc;

  function automatic bit is_tok(input logic [9:0] w);
    return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [9:0] x;
    x = w;
    for (int i = 0; i < r; i++) x = {x[8:0], x[9]};
    return x;
  endfunction

  function automatic logic [9:0] pick_tok(input int i);
    case (i)
      0:       return TOK0;
      1:       return TOK1;
      2:       return TOK2;
      default: return TOK3;
    endcase
  endfunction

  function automatic logic [9:0] rand_nontok();
    logic [9:0] w;
    w = 10'($urandom);
    if (is_tok(w)) w = 10'h000;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    cyc = 0; m_run = 0; m_win = 0; m_loss = 0; m_locked = 1'b0;
    m_settle_end = -1; m_slip_at = -1; m_lost_at = -1;
    m_phase = 0; m_invert = 1'b0;
    rx_off = 0; slip_count = 0; last_slip_cyc = -1000;
  endtask

  // One clock: drive inputs, advance the model, compare every output
  task automatic step(input bit v, input logic [9:0] w);
    word_valid = v;
    tmds_word  = w;
    @(posedge clk);
    cyc++;
    if (cyc == m_slip_at) begin
      m_phase = (m_phase + 1) % 10;
      if (m_phase == 0 && INV_EN) m_invert = !m_invert;
    end
    if (m_locked) begin
      if (v) begin
        if (is_tok(w)) m_loss = 0; else m_loss++;
        if (m_loss == LOSS_WINDOW) begin
          m_locked = 1'b0; m_loss = 0;
          m_lost_at = cyc; m_slip_at = cyc + 1;
          m_settle_end = cyc + 1 + SETTLE_CYCLES;
        end
      end
    end else if (cyc > m_settle_end && v) begin
      m_win++;
      m_run = is_tok(w) ? m_run + 1 : 0;
      if (m_run == CTRL_RUN) begin
        m_locked = 1'b1; m_loss = 0; m_run = 0; m_win = 0;
      end else if (m_win == SEARCH_WINDOW) begin
        m_run = 0; m_win = 0;
        m_slip_at = cyc + 1;
        m_settle_end = cyc + 1 + SETTLE_CYCLES;
      end
    end
    #1;
    chk("bitslip",   bitslip,   cyc == m_slip_at);
    chk("lock_lost", lock_lost, cyc == m_lost_at);
    chk("locked",    locked,    m_locked);
    chk("phase",     phase,     m_phase);
    chk("invert",    invert,    m_invert);
    if (bitslip === 1'b1) begin
      chk("slip_gap", (cyc - last_slip_cyc) >= int'(SETTLE_CYCLES + 2), 1);
      last_slip_cyc = cyc;
      slip_count++;
      rx_off = (rx_off + 1) % 10;
    end
  endtask

  // Raise rst between edges, check outputs clear before the next edge
  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_bitslip"},   bitslip,   0);
    chk({tag, "_phase"},     phase,     0);
    chk({tag, "_locked"},    locked,    0);
    chk({tag, "_lock_lost"}, lock_lost, 0);
    chk({tag, "_invert"},    invert,    0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_reset();
    #1;
    chk("por_bitslip", bitslip, 0);
    chk("por_phase",   phase,   0);
    chk("por_locked",  locked,  0);
    chk("por_lost",    lock_lost, 0);
    chk("por_invert",  invert,  0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Eight aligned tokens lock without any slip
    for (int i = 0; i < 8; i++) step(1'b1, TOK0);
    chk("r030_locked", locked, 1);
    chk("r030_phase",  phase,  0);
    chk("r030_slips",  slip_count, 0);
    async_rst("rst_locked");

    // Broken run with idle gaps; the 16th valid word ties lock and window
    for (int i = 0; i < 7; i++) begin
      step(1'b1, TOK1);
      step(1'b0, 10'h3ff);
    end
    step(1'b1, 10'h000);
    chk("r033_not_locked_a", locked, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("r033_not_locked_b", locked, 0);
      step(1'b1, TOK2);
      step(1'b0, TOK2 ^ 10'h001);
    end
    chk("r033_locked", locked, 1);
    chk("r033_slips",  slip_count, 0);
    async_rst("rst_r033");

    // Stream aligned only at offset 3
    n = 0;
    while (locked !== 1'b1 && n < 1000) begin
      step(($urandom_range(0, 3) != 0), rotl(TOK0, (13 - rx_off) % 10));
      n++;
    end
    chk("r031_locked", locked, 1);
    chk("r031_phase",  phase,  3);
    chk("r031_slips",  slip_count, 3);

    // Lose lock: LOSS_WINDOW non-tokens, then slip to phase 4
    for (int i = 0; i < int'(LOSS_WINDOW); i++) step(1'b1, rand_nontok());
    chk("r032_lost",     lock_lost, 1);
    chk("r032_unlocked", locked,    0);
    chk("r032_noslip",   bitslip,   0);
    step(1'b1, rand_nontok());
    chk("r032_slip",  bitslip, 1);
    chk("r032_phase", phase,   4);
    async_rst("rst_bitslip");

    // After reset the next slip waits for a full fresh window
    n = 0;
    while (bitslip !== 1'b1 && n < 100) begin
      step(1'b1, rand_nontok());
      n++;
    end
    chk("r035_slip_cycle", cyc, SEARCH_WINDOW + 1);
    for (int i = 0; i < 5; i++) step(1'b1, TOK0);
    async_rst("rst_settle");

    // Ten empty windows: phase wraps 9->0 with optional inversion toggle
    n = 0;
    while (slip_count < 10 && n < 1000) begin
      step(($urandom_range(0, 4) != 0), rand_nontok());
      n++;
    end
    chk("r034_slips",  slip_count, 10);
    chk("r034_phase",  phase,  0);
    chk("r034_invert", invert, INV_EN);
    for (int i = 0; i < 40; i++) step(1'b1, rand_nontok());
    async_rst("rst_r034");

    // Randomized token-rich traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 85) step(($urandom_range(0, 4) != 0), pick_tok(int'($urandom_range(0, 3))));
      else                           step(($urandom_range(0, 4) != 0), rand_nontok());
      if (i == 400) async_rst("rst_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
